// File: rtl/exec_fwd_pipe.sv
// In-flight result tracker and forwarding network for the execute stage.
// Tracks DEPTH writers, collects out-of-order results by tag, retires in order.
module exec_fwd_pipe #(
    parameter int DEPTH = 4,
    parameter int NREAD = 2,
    parameter int DATAW = 32,
    parameter int TAGW  = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic                        issue_fmode,
    input  logic [4:0]                  issue_rd,
    input  logic                        issue_done,
    input  logic [DATAW-1:0]            issue_data,
    output logic [TAGW-1:0]             issue_tag,

    input  logic                        res_valid,
    input  logic [TAGW-1:0]             res_tag,
    input  logic [DATAW-1:0]            res_data,

    input  logic [NREAD-1:0]            src_fmode,
    input  logic [NREAD-1:0][4:0]       src_no,
    input  logic [NREAD-1:0][DATAW-1:0] src_regval,
    output logic [NREAD-1:0][DATAW-1:0] fwd_data,
    output logic [NREAD-1:0]            fwd_stop,

    output logic                        wb_valid,
    output logic                        wb_fmode,
    output logic [4:0]                  wb_rd,
    output logic [DATAW-1:0]            wb_data,
    output logic                        res_orphan
);

    // Stage 0 is the youngest entry, stage DEPTH-1 the oldest.
    logic             v     [DEPTH];
    logic             fmode [DEPTH];
    logic [4:0]       rd    [DEPTH];
    logic [TAGW-1:0]  tag   [DEPTH];
    logic             rdy   [DEPTH];
    logic [DATAW-1:0] data  [DEPTH];

    logic [TAGW-1:0]  tag_cnt;

    logic [DEPTH-1:0] cap;
    logic             eff_rdy  [DEPTH];
    logic [DATAW-1:0] eff_data [DEPTH];
    logic             hold;

    // A bus result is captured only by a live entry still waiting for it;
    // anything else counts as an orphan.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            cap[k]      = v[k] & ~rdy[k] & res_valid & (res_tag == tag[k]);
            eff_rdy[k]  = rdy[k] | cap[k];
            eff_data[k] = cap[k] ? res_data : data[k];
        end
    end

    assign hold        = v[DEPTH-1] & ~eff_rdy[DEPTH-1];
    assign issue_ready = ~hold;
    assign issue_tag   = tag_cnt;

    // Youngest producer wins: scan oldest to youngest so stage 0 is written last.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic port_ok;
        port_ok = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            fwd_data[i] = src_regval[i];
            fwd_stop[i] = 1'b0;
            port_ok     = !((src_fmode[i] == 1'b0) && (src_no[i] == 5'd0));
            if (port_ok && wb_valid && (wb_fmode == src_fmode[i]) && (wb_rd == src_no[i])) begin
                fwd_data[i] = wb_data;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (port_ok && v[k] && (fmode[k] == src_fmode[i]) && (rd[k] == src_no[i])) begin
                    fwd_data[i] = eff_data[k];
                    fwd_stop[i] = ~eff_rdy[k];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload registers are reset too; the array is tiny and a
            // defined value keeps forwarding outputs free of X after reset.
            for (int k = 0; k < DEPTH; k++) begin
                v[k]     <= 1'b0;
                fmode[k] <= 1'b0;
                rd[k]    <= '0;
                tag[k]   <= '0;
                rdy[k]   <= 1'b0;
                data[k]  <= '0;
            end
            tag_cnt    <= '0;
            wb_valid   <= 1'b0;
            wb_fmode   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            res_orphan <= 1'b0;
        end else begin
            if (res_valid && (cap == '0)) begin
                res_orphan <= 1'b1;
            end

            if (hold) begin
                wb_valid <= 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (cap[k]) begin
                        rdy[k]  <= 1'b1;
                        data[k] <= res_data;
                    end
                end
            end else begin
                v[0]     <= issue_valid;
                fmode[0] <= issue_fmode;
                rd[0]    <= issue_rd;
                tag[0]   <= tag_cnt;
                rdy[0]   <= issue_valid & issue_done;
                data[0]  <= issue_data;
                for (int k = 1; k < DEPTH; k++) begin
                    v[k]     <= v[k-1];
                    fmode[k] <= fmode[k-1];
                    rd[k]    <= rd[k-1];
                    tag[k]   <= tag[k-1];
                    rdy[k]   <= eff_rdy[k-1];
                    data[k]  <= eff_data[k-1];
                end

                wb_valid <= v[DEPTH-1];
                if (v[DEPTH-1]) begin
                    wb_fmode <= fmode[DEPTH-1];
                    wb_rd    <= rd[DEPTH-1];
                    wb_data  <= eff_data[DEPTH-1];
                end

                if (issue_valid) begin
                    tag_cnt <= tag_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_fwd_pipe.sv
// Directed bench for exec_fwd_pipe: writebacks are checked against a
// scoreboard filled at issue time; forwarding is checked cycle by cycle.
module tb_exec_fwd_pipe;

    localparam int DEPTH = 4;
    localparam int NREAD = 2;
    localparam int DATAW = 32;
    localparam int TAGW  = 3;

    logic                        clk;
    logic                        rst;
    logic                        issue_valid;
    logic                        issue_ready;
    logic                        issue_fmode;
    logic [4:0]                  issue_rd;
    logic                        issue_done;
    logic [DATAW-1:0]            issue_data;
    logic [TAGW-1:0]             issue_tag;
    logic                        res_valid;
    logic [TAGW-1:0]             res_tag;
    logic [DATAW-1:0]            res_data;
    logic [NREAD-1:0]            src_fmode;
    logic [NREAD-1:0][4:0]       src_no;
    logic [NREAD-1:0][DATAW-1:0] src_regval;
    logic [NREAD-1:0][DATAW-1:0] fwd_data;
    logic [NREAD-1:0]            fwd_stop;
    logic                        wb_valid;
    logic                        wb_fmode;
    logic [4:0]                  wb_rd;
    logic [DATAW-1:0]            wb_data;
    logic                        res_orphan;

    exec_fwd_pipe #(
        .DEPTH(DEPTH), .NREAD(NREAD), .DATAW(DATAW), .TAGW(TAGW)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fmode(issue_fmode), .issue_rd(issue_rd),
        .issue_done(issue_done), .issue_data(issue_data), .issue_tag(issue_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .src_fmode(src_fmode), .src_no(src_no), .src_regval(src_regval),
        .fwd_data(fwd_data), .fwd_stop(fwd_stop),
        .wb_valid(wb_valid), .wb_fmode(wb_fmode), .wb_rd(wb_rd), .wb_data(wb_data),
        .res_orphan(res_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [37:0] sb [$];
    logic [TAGW-1:0] exp_tag;
    logic [TAGW-1:0] lost_tag;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Compares any writeback of the current cycle, then advances to 1ns after the next edge.
    task automatic next_cycle();
        logic [37:0] e;
        if (!rst && wb_valid) begin
            if (sb.size() > 0) e = sb.pop_front();
            else               e = 'x;
            check("wb_entry", {wb_fmode, wb_rd, wb_data}, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_done  = 1'b0;
        issue_data  = '0;
        res_valid   = 1'b0;
    endtask

    task automatic do_issue(input logic fm, input logic [4:0] r, input logic done,
                            input logic [31:0] d, input logic [31:0] exp_d);
        check("issue_ready", issue_ready, 1'b1);
        check("issue_tag", issue_tag, exp_tag);
        issue_valid = 1'b1;
        issue_fmode = fm;
        issue_rd    = r;
        issue_done  = done;
        issue_data  = d;
        sb.push_back({fm, r, exp_d});
        exp_tag = exp_tag + 1'b1;
    endtask

    task automatic look(input int p, input logic fm, input logic [4:0] r, input logic [31:0] rv);
        src_fmode[p]  = fm;
        src_no[p]     = r;
        src_regval[p] = rv;
    endtask

    task automatic chk_fwd(input string name, input int p, input logic [31:0] d, input logic s);
        #1;
        check({name, "_data"}, fwd_data[p], d);
        check({name, "_stop"}, fwd_stop[p], s);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        sb.delete();
        exp_tag = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        issue_fmode = 1'b0;
        issue_rd    = '0;
        res_tag     = '0;
        res_data    = '0;
        src_fmode   = '0;
        src_no      = '0;
        src_regval  = '0;
        exp_tag     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_issue_tag", issue_tag, 0);
        check("rst_wb", {wb_valid, wb_fmode, wb_rd, wb_data}, 0);
        check("rst_orphan", res_orphan, 1'b0);
        look(0, 1'b0, 5'd5, 32'hCAFE);
        chk_fwd("rst_fwd", 0, 32'hCAFE, 1'b0);

        // A: ready-at-issue writer, forwarded from every stage then wb
        reset_dut();
        do_issue(1'b0, 5'd5, 1'b1, 32'h11, 32'h11);
        next_cycle();
        idle();
        for (int c = 1; c <= 5; c++) begin
            look(0, 1'b0, 5'd5, 32'hDEAD);
            look(1, 1'b1, 5'd5, 32'hBEEF);
            chk_fwd($sformatf("A_r5_c%0d", c), 0, 32'h11, 1'b0);
            check($sformatf("A_wbv_c%0d", c), wb_valid, c == 5);
            if (c == 1) chk_fwd("A_f5_bank", 1, 32'hBEEF, 1'b0);
            next_cycle();
        end

        // B: pending float writer stalls the pipe until its result arrives
        reset_dut();
        do_issue(1'b1, 5'd3, 1'b0, 32'h0, 32'h3F800000);
        next_cycle();
        idle();
        for (int c = 1; c <= 5; c++) begin
            look(0, 1'b1, 5'd3, 32'h0);
            #1;
            check($sformatf("B_stop_c%0d", c), fwd_stop[0], 1'b1);
            check($sformatf("B_ready_c%0d", c), issue_ready, c < 4);
            if (c == 5) begin
                issue_valid = 1'b1;
                issue_rd    = 5'd9;
                issue_done  = 1'b1;
                issue_data  = 32'h99;
            end
            next_cycle();
        end
        idle();
        res_valid = 1'b1;
        res_tag   = 3'd0;
        res_data  = 32'h3F800000;
        look(0, 1'b1, 5'd3, 32'h0);
        chk_fwd("B_bypass", 0, 32'h3F800000, 1'b0);
        check("B_ready6", issue_ready, 1'b1);
        check("B_tag6", issue_tag, exp_tag);
        next_cycle();
        res_valid = 1'b0;
        check("B_wbv7", wb_valid, 1'b1);
        chk_fwd("B_wbfwd", 0, 32'h3F800000, 1'b0);
        check("B_orphan", res_orphan, 1'b0);
        repeat (5) next_cycle();

        // C: youngest writer wins; bank must match
        do_issue(1'b0, 5'd7, 1'b1, 32'd1, 32'd1);
        next_cycle();
        do_issue(1'b0, 5'd7, 1'b1, 32'd2, 32'd2);
        next_cycle();
        idle();
        look(0, 1'b0, 5'd7, 32'hAAAA);
        look(1, 1'b1, 5'd7, 32'hBBBB);
        chk_fwd("C_young", 0, 32'd2, 1'b0);
        chk_fwd("C_bank", 1, 32'hBBBB, 1'b0);
        next_cycle();

        // D: r0 never forwards but still writes back; f0 forwards
        do_issue(1'b0, 5'd0, 1'b1, 32'hFFFF, 32'hFFFF);
        next_cycle();
        do_issue(1'b1, 5'd0, 1'b1, 32'h55, 32'h55);
        look(0, 1'b0, 5'd0, 32'h1234);
        chk_fwd("D_r0", 0, 32'h1234, 1'b0);
        next_cycle();
        idle();
        look(1, 1'b1, 5'd0, 32'h77);
        chk_fwd("D_f0", 1, 32'h55, 1'b0);
        next_cycle();
        repeat (6) next_cycle();
        check("CD_drained", sb.size(), 0);

        // E: results return as tags 2,0,1; retirement stays in issue order
        reset_dut();
        do_issue(1'b0, 5'd1, 1'b0, 32'h0, 32'h200);
        next_cycle();
        do_issue(1'b0, 5'd2, 1'b0, 32'h0, 32'h211);
        next_cycle();
        do_issue(1'b0, 5'd3, 1'b0, 32'h0, 32'h222);
        look(0, 1'b0, 5'd1, 32'h9);
        #1;
        check("E_r1_pending", fwd_stop[0], 1'b1);
        next_cycle();
        idle();
        res_valid = 1'b1;
        res_tag   = 3'd2;
        res_data  = 32'h222;
        look(1, 1'b0, 5'd3, 32'h0);
        chk_fwd("E_bypass", 1, 32'h222, 1'b0);
        next_cycle();
        res_tag  = 3'd0;
        res_data = 32'h200;
        #1;
        check("E_noholdbus", issue_ready, 1'b1);
        next_cycle();
        res_tag  = 3'd1;
        res_data = 32'h211;
        next_cycle();
        res_valid = 1'b0;
        repeat (3) next_cycle();
        check("E_orphan", res_orphan, 1'b0);
        check("E_drained", sb.size(), 0);

        // F: orphan result, then reset mid-stream discards in-flight work
        res_valid = 1'b1;
        res_tag   = 3'd5;
        res_data  = 32'h0;
        next_cycle();
        res_valid = 1'b0;
        check("F_orphan_set", res_orphan, 1'b1);
        lost_tag = issue_tag;
        do_issue(1'b0, 5'd4, 1'b0, 32'h0, 32'h44);
        next_cycle();
        idle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("F_rst_wb", {wb_valid, wb_fmode, wb_rd, wb_data}, 0);
        check("F_rst_orphan", res_orphan, 1'b0);
        check("F_rst_ready", issue_ready, 1'b1);
        check("F_rst_tag", issue_tag, 0);
        look(0, 1'b0, 5'd4, 32'h4444);
        chk_fwd("F_rst_fwd", 0, 32'h4444, 1'b0);
        sb.delete();
        exp_tag = '0;
        next_cycle();
        rst = 1'b0;
        res_valid = 1'b1;
        res_tag   = lost_tag;
        res_data  = 32'h44;
        next_cycle();
        res_valid = 1'b0;
        check("F_late_orphan", res_orphan, 1'b1);
        repeat (5) next_cycle();
        check("F_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
